// File: rtl/interval_pkg.sv
// Shared constants, state encoding and helpers for the interval arbiter.
// NREQ requesters share a single CW-bit interval counter.
package interval_pkg;
   localparam int NREQ = 4;
   localparam int CW   = 16;
   localparam int IW   = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Holds at all-ones so the counter can never wrap.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans from last_grant+1 and wraps.
// Produces a one-hot winner and its index; win is all-zero when req is empty.
module rr_picker
   import interval_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   index
);
   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      win   = '0;
      index = '0;
      found = 1'b0;
      idx   = '0;
      // k = NREQ wraps back to last_grant itself, so it is checked last.
      for (int k = 1; k <= NREQ; k++) begin
         idx = last_grant + IW'(k);
         if (!found && req[idx]) begin
            found      = 1'b1;
            win[idx]   = 1'b1;
            index      = idx;
         end
      end
   end
endmodule

// File: rtl/interval_arbiter.sv
// Round-robin owner of one shared interval counter: grants a requester, counts
// to its latched limit, pulses done on expiry, and supports abort and enable.
module interval_arbiter
   import interval_pkg::*;
(
   input  logic                 tick,
   input  logic                 clear_n,
   input  logic                 en,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   limit,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [CW-1:0]        count
);
   state_t          state;
   logic [CW-1:0]   lim_q;
   logic [IW-1:0]   last_grant;
   logic [NREQ-1:0] win;
   logic [IW-1:0]   win_idx;
   logic [CW-1:0]   lim_sel;
   logic            owner_req;

   rr_picker u_pick (
      .req        (req),
      .last_grant (last_grant),
      .win        (win),
      .index      (win_idx)
   );

   assign lim_sel   = limit[int'(win_idx)*CW +: CW];
   // grant is one-hot, so masking req with it isolates the owner's request.
   assign owner_req = |(req & grant);

   always_ff @(posedge tick or negedge clear_n) begin
      if (!clear_n) begin
         state      <= IDLE;
         grant      <= '0;
         done       <= '0;
         busy       <= 1'b0;
         count      <= '0;
         lim_q      <= '0;
         last_grant <= IW'(NREQ-1);
      end else if (!en) begin
         state <= IDLE;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state      <= RUN;
                  grant      <= win;
                  busy       <= 1'b1;
                  count      <= '0;
                  lim_q      <= lim_sel;
                  last_grant <= win_idx;
               end
            end
            RUN: begin
               if (!owner_req) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  count <= '0;
               end else if (count == lim_q) begin
                  state <= DONE;
                  done  <= grant;
                  count <= sat_inc(count);
               end else begin
                  count <= sat_inc(count);
               end
            end
            DONE: begin
               // count keeps limit+1 until the next grant.
               state <= IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_interval_arbiter.sv
// Directed bench for interval_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for async reset mid-interval and counter saturation.
module tb_interval_arbiter;
   logic        tick = 1'b0;
   logic        clear_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [63:0] limit = 64'b0;
   logic [3:0]  grant, done;
   logic        busy;
   logic [15:0] count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        clr;
      logic        en;
      logic [3:0]  req;
      logic [63:0] limit;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        busy;
      logic [15:0] count;
   } vec_t;

   vec_t vq[$];

   interval_arbiter dut (
      .tick    (tick),
      .clear_n (clear_n),
      .en      (en),
      .req     (req),
      .limit   (limit),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .count   (count)
   );

   always #5 tick = ~tick;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [15:0] c);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".done"},  32'(done),  32'(d));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".count"}, 32'(count), 32'(c));
   endtask

   task automatic add(input logic c, input logic e, input logic [3:0] r, input logic [63:0] l,
                      input logic [3:0] g, input logic [3:0] d, input logic b, input logic [15:0] cnt);
      vq.push_back('{c, e, r, l, g, d, b, cnt});
   endtask

   initial begin
      // Basic interval, limit0 = 2
      add(0,1,4'h1,64'd2,   4'h1,4'h0,1,16'd0);
      add(0,1,4'h1,64'd2,   4'h1,4'h0,1,16'd1);
      add(0,1,4'h1,64'd2,   4'h1,4'h0,1,16'd2);
      add(0,1,4'h1,64'd2,   4'h1,4'h1,1,16'd3);
      add(0,1,4'h0,64'd2,   4'h0,4'h0,0,16'd3);
      add(1,0,4'h0,64'd0,   4'h0,4'h0,0,16'd0);
      // All four requesting, zero limits: rotation from requester 0
      add(0,1,4'hF,64'd0,   4'h1,4'h0,1,16'd0);
      add(0,1,4'hF,64'd0,   4'h1,4'h1,1,16'd1);
      add(0,1,4'hF,64'd0,   4'h0,4'h0,0,16'd1);
      add(0,1,4'hF,64'd0,   4'h2,4'h0,1,16'd0);
      add(0,1,4'hF,64'd0,   4'h2,4'h2,1,16'd1);
      add(0,1,4'hF,64'd0,   4'h0,4'h0,0,16'd1);
      add(0,1,4'hF,64'd0,   4'h4,4'h0,1,16'd0);
      add(0,1,4'hF,64'd0,   4'h4,4'h4,1,16'd1);
      add(0,1,4'hF,64'd0,   4'h0,4'h0,0,16'd1);
      add(0,1,4'hF,64'd0,   4'h8,4'h0,1,16'd0);
      add(0,1,4'hF,64'd0,   4'h8,4'h8,1,16'd1);
      add(0,1,4'hF,64'd0,   4'h0,4'h0,0,16'd1);
      add(0,1,4'hF,64'd0,   4'h1,4'h0,1,16'd0);
      add(0,1,4'hF,64'd0,   4'h1,4'h1,1,16'd1);
      // Abort at count 4 with limit0 = 10
      add(0,1,4'h1,64'd10,  4'h0,4'h0,0,16'd1);
      add(0,1,4'h1,64'd10,  4'h1,4'h0,1,16'd0);
      add(0,1,4'h1,64'd10,  4'h1,4'h0,1,16'd1);
      add(0,1,4'h1,64'd10,  4'h1,4'h0,1,16'd2);
      add(0,1,4'h1,64'd10,  4'h1,4'h0,1,16'd3);
      add(0,1,4'h1,64'd10,  4'h1,4'h0,1,16'd4);
      add(0,1,4'h0,64'd10,  4'h0,4'h0,0,16'd0);
      add(0,1,4'h0,64'd10,  4'h0,4'h0,0,16'd0);
      // en dropped when count == limit1 (2), then re-raised
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd0);
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd1);
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd2);
      add(0,0,4'h2,64'h20000, 4'h0,4'h0,0,16'd0);
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd0);
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd1);
      add(0,1,4'h2,64'h20000, 4'h2,4'h0,1,16'd2);
      add(0,1,4'h2,64'h20000, 4'h2,4'h2,1,16'd3);
      add(0,1,4'h0,64'h20000, 4'h0,4'h0,0,16'd3);
      // limit0 changed 3 -> 100 after the grant edge
      add(0,1,4'h1,64'd3,   4'h1,4'h0,1,16'd0);
      add(0,1,4'h1,64'd100, 4'h1,4'h0,1,16'd1);
      add(0,1,4'h1,64'd100, 4'h1,4'h0,1,16'd2);
      add(0,1,4'h1,64'd100, 4'h1,4'h0,1,16'd3);
      add(0,1,4'h1,64'd100, 4'h1,4'h1,1,16'd4);
      add(0,1,4'h0,64'd100, 4'h0,4'h0,0,16'd4);

      #12;
      chk_all("reset", 4'h0, 4'h0, 1'b0, 16'd0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge tick);
         clear_n = ~vq[i].clr;
         en      = vq[i].en;
         req     = vq[i].req;
         limit   = vq[i].limit;
         @(posedge tick); #1;
         chk_all($sformatf("v%0d", i), vq[i].grant, vq[i].done, vq[i].busy, vq[i].count);
      end

      // Async reset mid-interval, req2 pending
      @(negedge tick);
      req = 4'b0001; limit = {16'd0, 16'd7, 16'd0, 16'd20};
      @(posedge tick); #1;
      chk_all("rst.grant0", 4'h1, 4'h0, 1'b1, 16'd0);
      @(negedge tick);
      req = 4'b0101;
      repeat (5) @(posedge tick);
      #1;
      chk_all("rst.cnt5", 4'h1, 4'h0, 1'b1, 16'd5);
      #2;
      clear_n = 1'b0; req = 4'b0100;
      #1;
      chk_all("rst.async", 4'h0, 4'h0, 1'b0, 16'd0);
      @(negedge tick);
      clear_n = 1'b1;
      @(posedge tick); #1;
      chk_all("rst.req2", 4'h4, 4'h0, 1'b1, 16'd0);
      @(posedge tick); #1;
      chk_all("rst.req2c1", 4'h4, 4'h0, 1'b1, 16'd1);

      // Maximum limit: expiry at 16'hFFFF, count saturates
      @(negedge tick);
      clear_n = 1'b0; req = 4'b0000;
      @(negedge tick);
      clear_n = 1'b1; req = 4'b0001; limit = 64'h0000_0000_0000_FFFF;
      @(posedge tick); #1;
      chk_all("sat.grant", 4'h1, 4'h0, 1'b1, 16'd0);
      repeat (65535) @(posedge tick);
      #1;
      chk_all("sat.ffff", 4'h1, 4'h0, 1'b1, 16'hFFFF);
      @(posedge tick); #1;
      chk_all("sat.done", 4'h1, 4'h1, 1'b1, 16'hFFFF);
      @(negedge tick);
      req = 4'b0000;
      @(posedge tick); #1;
      chk_all("sat.idle", 4'h0, 4'h0, 1'b0, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
